freq_meter: RTL and testbench
=============================

# freq_meter

Gated frequency/period meter that sits directly downstream of the frequency divider and consumes its divided output. It counts rising edges of `sig_in` over a fixed window of `GATE_CYCLES` clock cycles. It also captures the period, in clock cycles, of the last complete `sig_in` cycle inside that window, and reports both results with a one-cycle `valid` strobe. This lets the selected division ratio be checked in-system and in simulation.

## Interface
- `GATE_CYCLES`, default 1000: gate window length in clock cycles; legal range is 2 to 2^32-1.
- `CNT_W`, default 16: width of the edge counter and of `freq_cnt`.
- `clk`  in  1: the single clock, the same one that clocks the divider output register. All logic uses the rising edge.
- `reset`  in  1: synchronous, active-high; it takes effect on the rising edge of `clk`.
- `en`  in  1: measurement enable; level-sensitive.
- `sig_in`  in  1: divided signal; already registered on `clk`, so no synchronizer is required.
- `freq_cnt`  out  CNT_W: rising edges counted in the last completed window.
- `period`  out  32: clock cycles between the last two rising edges in the last completed window, or 0 if that window had fewer than 2 edges.
- `ovf`  out  1: set if the last completed window saturated the edge counter or the period counter.
- `valid`  out  1: one-cycle strobe; the other outputs are updated and stable in the same cycle.
- `busy`  out  1: high in the ARM, GATE and REPORT states.

## Operation
- **Edge detect:** `sig_d` is `sig_in` delayed one cycle, and `rise = sig_in & ~sig_d`.
  - `sig_d` resets to 1, so a `sig_in` that is already high when reset is released is not counted as an edge.
- **FSM states:** IDLE, ARM, GATE, REPORT. The reset state is IDLE.
  - IDLE: when `en`=1, go to ARM next cycle.
  - ARM: wait for `rise`. On `rise`:
    - clear the edge count;
    - clear the gate counter;
    - set the period counter to 1;
    - go to GATE.
    - The arming edge itself is not counted.
  - GATE: lasts exactly `GATE_CYCLES` cycles. In each cycle:
    - increment the gate counter;
    - on `rise`, increment the edge count (saturating at 2^CNT_W-1);
    - on `rise`, move the period counter value into the period capture register and set the period counter back to 1;
    - with no `rise`, increment the period counter (saturating at 2^32-1).
    - A `rise` on the final GATE cycle is counted.
  - REPORT: a single cycle.
    - `freq_cnt`, `period`, `ovf` load at the GATE→REPORT transition.
    - `valid`=1 during REPORT.
    - Next state is ARM if `en`=1, otherwise IDLE.
    - A `rise` during REPORT is ignored; arming waits for the next `rise` seen in ARM.
- **Period capture register:** cleared on the arming edge. A window with a single edge therefore reports `period`=0.
- **`ovf`:** set if the edge counter or the period counter saturated during the window.
- **`en`=0 in ARM or GATE:** abort to IDLE on the next edge. No `valid`; `freq_cnt`, `period`, `ovf` keep their previous values.
- **Simultaneous `en` drop and last GATE cycle:** the window still completes and REPORT runs; then go to IDLE.
- **`reset` during any state, including REPORT:** next cycle is IDLE, and every output reads 0 except `busy`=0. `valid` is suppressed even if the window had just ended.
- **Output holding:** outputs hold between reports; only REPORT and reset change them.

## Timing
- **Reset values:** `freq_cnt`=0, `period`=0, `ovf`=0, `valid`=0, `busy`=0.
- **Arming:** the arming `rise` happens in cycle t0. GATE covers cycles t0+1 … t0+GATE_CYCLES.
- **Report:** REPORT and `valid` occur in cycle t0+GATE_CYCLES+1. The earliest new ARM cycle is t0+GATE_CYCLES+2.
- **`busy`:** goes high the cycle after `en` is sampled high in IDLE. It goes low the cycle after REPORT if `en`=0, or the cycle after an abort.
- **Edge latency:** a rise is recognized in the first cycle `sig_in` is high, with zero added latency relative to the divider output.
- **Period definition:** `period` is the distance between the clock cycles of two consecutive rises. A 1-high/1-low toggle gives 2.

## Test plan
- **Nominal window:** `GATE_CYCLES`=100, `sig_in` with period 10 (5 high / 5 low), `en`=1 → first `valid` at t0+101 with `freq_cnt`=10, `period`=10, `ovf`=0. The next reports repeat the same values.
- **Fastest input and counter saturation:** `sig_in` toggling every cycle, `GATE_CYCLES`=100, `CNT_W`=16 → `freq_cnt`=50, `period`=2. Then with `CNT_W`=4 → `freq_cnt`=15, `ovf`=1.
- **Slow input:** `sig_in` period 150, `GATE_CYCLES`=100 → `freq_cnt`=0, `period`=0. Then period 60 → `freq_cnt`=1, `period`=0.
- **Reset with `sig_in` high:** `sig_in` held high through reset release → no edge counted. Arming waits for a genuine 0→1 transition.
- **Abort with `en`:** `en` dropped at t0+50 → no `valid`, the prior outputs hold, `busy`=0 from t0+51. Re-asserting `en` re-arms on the next rise.
- **Reset mid-GATE and in REPORT:** `reset` at t0+40 → all outputs 0 the next cycle and the state is IDLE. `reset` in the REPORT cycle → no `valid` seen after the reset edge.

Source files
------------

// File: rtl/freq_meter.sv
// Gated frequency/period meter: counts sig_in rising edges over a GATE_CYCLES
// window and captures the period of the last complete sig_in cycle in it.
module freq_meter #(
    parameter logic [31:0] GATE_CYCLES = 32'd1000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_cnt,
    output logic [31:0]      period,
    output logic             ovf,
    output logic             valid,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        GATE   = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] EDGE_MAX = {CNT_W{1'b1}};
    localparam logic [31:0]      PER_MAX  = 32'hFFFF_FFFF;

    state_t           state;
    logic             sig_d;
    logic             rise;
    logic             last_gate;
    logic [31:0]      gate_cnt;
    logic [31:0]      per_cnt;
    logic [31:0]      per_cap;
    logic [CNT_W-1:0] edge_cnt;
    logic             edge_sat;
    logic             per_sat;

    logic [CNT_W-1:0] edge_nxt;
    logic [31:0]      per_cnt_nxt;
    logic [31:0]      per_cap_nxt;
    logic             edge_sat_nxt;
    logic             per_sat_nxt;

    assign rise      = sig_in & ~sig_d;
    assign last_gate = (gate_cnt == (GATE_CYCLES - 32'd1));

    // Window counter updates for one GATE cycle; the first in-window edge
    // only restarts the period count so a single-edge window reports 0.
    always_comb begin
        edge_nxt     = edge_cnt;
        edge_sat_nxt = edge_sat;
        per_cnt_nxt  = per_cnt;
        per_cap_nxt  = per_cap;
        per_sat_nxt  = per_sat;
        if (rise) begin
            if (edge_cnt == EDGE_MAX) begin
                edge_sat_nxt = 1'b1;
            end else begin
                edge_nxt = edge_cnt + CNT_W'(1);
            end
            if (edge_cnt != {CNT_W{1'b0}}) begin
                per_cap_nxt = per_cnt;
            end else begin
                per_cap_nxt = per_cap;
            end
            per_cnt_nxt = 32'd1;
        end else begin
            if (per_cnt == PER_MAX) begin
                per_sat_nxt = 1'b1;
            end else begin
                per_cnt_nxt = per_cnt + 32'd1;
            end
        end
    end

    // Measurement FSM with registered results and strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sig_d    <= 1'b1;
            gate_cnt <= 32'd0;
            per_cnt  <= 32'd0;
            per_cap  <= 32'd0;
            edge_cnt <= {CNT_W{1'b0}};
            edge_sat <= 1'b0;
            per_sat  <= 1'b0;
            freq_cnt <= {CNT_W{1'b0}};
            period   <= 32'd0;
            ovf      <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            sig_d <= sig_in;
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= ARM;
                        busy  <= 1'b1;
                    end
                end
                ARM: begin
                    if (!en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (rise) begin
                        state    <= GATE;
                        gate_cnt <= 32'd0;
                        per_cnt  <= 32'd1;
                        per_cap  <= 32'd0;
                        edge_cnt <= {CNT_W{1'b0}};
                        edge_sat <= 1'b0;
                        per_sat  <= 1'b0;
                    end
                end
                GATE: begin
                    gate_cnt <= gate_cnt + 32'd1;
                    edge_cnt <= edge_nxt;
                    edge_sat <= edge_sat_nxt;
                    per_cnt  <= per_cnt_nxt;
                    per_cap  <= per_cap_nxt;
                    per_sat  <= per_sat_nxt;
                    // Completing the window wins over a simultaneous en drop.
                    if (last_gate) begin
                        state    <= REPORT;
                        freq_cnt <= edge_nxt;
                        period   <= per_cap_nxt;
                        ovf      <= edge_sat_nxt | per_sat_nxt;
                        valid    <= 1'b1;
                    end else if (!en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                REPORT: begin
                    if (en) begin
                        state <= ARM;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: two instances (16-bit and 4-bit edge
// counters) share stimulus and are compared every cycle against a window model.
module tb_freq_meter;

    localparam int G = 100;
    localparam int M_IDLE = 0, M_ARM = 1, M_GATE = 2, M_REPORT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        sig_in = 1'b1;
    logic [15:0] freq16;
    logic [3:0]  freq4;
    logic [31:0] period16, period4;
    logic        ovf16, ovf4, valid16, valid4, busy16, busy4;

    int checks = 0;
    int errors = 0;

    freq_meter #(.GATE_CYCLES(32'd100), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .en(en), .sig_in(sig_in),
        .freq_cnt(freq16), .period(period16), .ovf(ovf16), .valid(valid16), .busy(busy16)
    );

    freq_meter #(.GATE_CYCLES(32'd100), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .en(en), .sig_in(sig_in),
        .freq_cnt(freq4), .period(period4), .ovf(ovf4), .valid(valid4), .busy(busy4)
    );

    initial forever #5 clk = ~clk;

    // Signal generator: per_len-cycle period, low first then hi_len high.
    int per_len = 10;
    int hi_len = 5;
    bit force_high = 1'b1;
    int phase = 0;
    initial forever begin
        @(negedge clk);
        if (force_high) begin
            sig_in = 1'b1;
        end else begin
            if (phase >= per_len) phase = 0;
            sig_in = (phase >= per_len - hi_len);
            phase = (phase + 1 >= per_len) ? 0 : phase + 1;
        end
    end

    // Reference model: timestamps of rises inside each window.
    int  m_mode = M_IDLE;
    int  m_cyc = 0;
    int  m_t0 = 0;
    bit  m_sd = 1'b1;
    bit  started = 1'b0;
    int  rises[$];
    logic [31:0] e_freq16, e_freq4, e_period;
    logic        e_ovf16, e_ovf4, e_valid, e_busy;
    initial begin
        bit r;
        int n;
        e_freq16 = 0; e_freq4 = 0; e_period = 0;
        e_ovf16 = 0; e_ovf4 = 0; e_valid = 0; e_busy = 0;
        forever begin
            @(posedge clk);
            m_cyc++;
            r = sig_in && !m_sd;
            m_sd = reset ? 1'b1 : sig_in;
            if (reset) begin
                m_mode = M_IDLE;
                e_freq16 = 0; e_freq4 = 0; e_period = 0;
                e_ovf16 = 0; e_ovf4 = 0; e_valid = 0; e_busy = 0;
                started = 1'b1;
            end else begin
                e_valid = 0;
                case (m_mode)
                    M_IDLE: if (en) m_mode = M_ARM;
                    M_ARM: begin
                        if (!en) m_mode = M_IDLE;
                        else if (r) begin
                            m_t0 = m_cyc;
                            rises.delete();
                            m_mode = M_GATE;
                        end
                    end
                    M_GATE: begin
                        if (r) rises.push_back(m_cyc);
                        if (m_cyc - m_t0 == G) begin
                            n = rises.size();
                            e_freq16 = (n > 65535) ? 65535 : n;
                            e_freq4  = (n > 15) ? 15 : n;
                            e_ovf16  = (n > 65535);
                            e_ovf4   = (n > 15);
                            e_period = (n >= 2) ? rises[n-1] - rises[n-2] : 0;
                            e_valid  = 1;
                            m_mode   = M_REPORT;
                        end else if (!en) begin
                            m_mode = M_IDLE;
                        end
                    end
                    default: m_mode = en ? M_ARM : M_IDLE;
                endcase
                e_busy = (m_mode != M_IDLE);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("freq16", 32'(freq16), e_freq16);
            chk("period16", period16, e_period);
            chk("ovf16", 32'(ovf16), 32'(e_ovf16));
            chk("valid16", 32'(valid16), 32'(e_valid));
            chk("busy16", 32'(busy16), 32'(e_busy));
            chk("freq4", 32'(freq4), e_freq4);
            chk("period4", period4, e_period);
            chk("ovf4", 32'(ovf4), 32'(e_ovf4));
            chk("valid4", 32'(valid4), 32'(e_valid));
            chk("busy4", 32'(busy4), 32'(e_busy));
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_valid(input int bound, input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!valid16 && k < bound);
        if (!valid16) begin
            checks++;
            errors++;
            $display("FAIL %s: no valid within %0d cycles", name, bound);
        end
    endtask

    task automatic wait_gate(input int bound, input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(m_mode == M_GATE && m_cyc == m_t0) && k < bound);
        if (!(m_mode == M_GATE && m_cyc == m_t0)) begin
            checks++;
            errors++;
            $display("FAIL %s: no arming within %0d cycles", name, bound);
        end
    endtask

    task automatic wait_gate_cyc(input int off);
        int k;
        k = 0;
        while (m_cyc != m_t0 + off && k < 2 * G) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        // Reset with sig_in held high through release.
        cycles(3);
        en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cycles(20);
        chk("lit_high_busy", 32'(busy16), 32'd1);
        chk("lit_high_novalid", 32'(valid16), 32'd0);
        chk("lit_high_freq", 32'(freq16), 32'd0);

        // Nominal period 10.
        force_high = 1'b0; per_len = 10; hi_len = 5;
        wait_valid(300, "nom1");
        chk("lit_nom_freq", 32'(freq16), 32'd10);
        chk("lit_nom_period", period16, 32'd10);
        chk("lit_nom_ovf", 32'(ovf16), 32'd0);
        chk("lit_nom_freq4", 32'(freq4), 32'd10);
        wait_valid(300, "nom2");
        chk("lit_nom2_freq", 32'(freq16), 32'd10);
        chk("lit_nom2_period", period16, 32'd10);

        // Abort at t0+50: outputs hold, busy drops at t0+51.
        wait_gate(200, "abort_arm");
        wait_gate_cyc(49);
        en = 1'b0;
        @(negedge clk);
        chk("lit_abort_busy", 32'(busy16), 32'd0);
        chk("lit_abort_freq", 32'(freq16), 32'd10);
        chk("lit_abort_period", period16, 32'd10);
        cycles(5);
        en = 1'b1;
        wait_valid(300, "rearm");
        chk("lit_rearm_freq", 32'(freq16), 32'd10);

        // en dropped in the last GATE cycle: window still reports.
        wait_gate(200, "last_arm");
        wait_gate_cyc(G - 1);
        en = 1'b0;
        wait_valid(3, "last_report");
        chk("lit_last_freq", 32'(freq16), 32'd10);
        @(negedge clk);
        chk("lit_last_busy", 32'(busy16), 32'd0);
        en = 1'b1;

        // Fastest input: toggle every cycle.
        per_len = 2; hi_len = 1;
        wait_valid(300, "tog_a");
        wait_valid(300, "tog_b");
        chk("lit_tog_freq", 32'(freq16), 32'd50);
        chk("lit_tog_period", period16, 32'd2);
        chk("lit_tog_ovf", 32'(ovf16), 32'd0);
        chk("lit_tog_freq4", 32'(freq4), 32'd15);
        chk("lit_tog_ovf4", 32'(ovf4), 32'd1);

        // Slow inputs.
        per_len = 150; hi_len = 75;
        wait_valid(800, "slow150_a");
        wait_valid(800, "slow150_b");
        chk("lit_150_freq", 32'(freq16), 32'd0);
        chk("lit_150_period", period16, 32'd0);
        per_len = 60; hi_len = 30;
        wait_valid(800, "slow60_a");
        wait_valid(800, "slow60_b");
        chk("lit_60_freq", 32'(freq16), 32'd1);
        chk("lit_60_period", period16, 32'd0);

        // Reset at t0+40.
        per_len = 10; hi_len = 5;
        wait_valid(300, "pre_rst");
        wait_gate(200, "rst_arm");
        wait_gate_cyc(39);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("lit_rst_freq", 32'(freq16), 32'd0);
        chk("lit_rst_busy", 32'(busy16), 32'd0);
        chk("lit_rst_period", period16, 32'd0);

        // Reset in the REPORT cycle.
        wait_valid(400, "rpt_valid");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("lit_rptrst_valid", 32'(valid16), 32'd0);
        chk("lit_rptrst_freq", 32'(freq16), 32'd0);
        cycles(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
